// File: rtl/frost32_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// frost32_irq_ctrl_pkg
//   Shared types and helpers for the Frost32 interrupt controller slice.
//   Holds the controller state enum, the channel-count ceiling and the width
//   helpers for the channel id and the pulse/gap counter.
//   The optional IRQ_CTRL_EDGE_DETECT_EN macro is handled in the top module.
// ---------------------------------------------------------------------------
package frost32_irq_ctrl_pkg;

  // Upper bound on request channels; one pending bit per channel
  localparam int MAX_CHANNELS = 32;

  // Controller states: waiting, driving the pulse, enforcing the cool-down
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } IrqCtrlState;

  // Width of a channel id; a single channel still needs one bit
  function automatic int idWidth(input int numChannels);
    return (numChannels <= 1) ? 1 : $clog2(numChannels);
  endfunction

  // Width of the shared pulse/gap down-counter
  function automatic int countWidth(input int pulseCycles, input int gapCycles);
    int largest;
    largest = (pulseCycles > gapCycles) ? pulseCycles : gapCycles;
    return $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/frost32_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// frost32_irq_ctrl_if
//   Bundles the request, stall and interrupt signals between the interrupt
//   controller and its environment (request sources, MainMem, Frost32Cpu).
//   master : drives irq_src, irq_mask, wait_for_mem; observes the outputs
//   slave  : the controller; drives interrupt, irq_id, pending, busy
// ---------------------------------------------------------------------------
interface frost32_irq_ctrl_if
  import frost32_irq_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
);

  localparam int IDW = idWidth(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] irq_src;
  logic [NUM_CHANNELS-1:0] irq_mask;
  logic                    wait_for_mem;
  logic                    interrupt;
  logic [IDW-1:0]          irq_id;
  logic [NUM_CHANNELS-1:0] pending;
  logic                    busy;

  modport master (
    output irq_src, irq_mask, wait_for_mem,
    input  interrupt, irq_id, pending, busy
  );

  modport slave (
    input  irq_src, irq_mask, wait_for_mem,
    output interrupt, irq_id, pending, busy
  );

endinterface

// File: rtl/frost32_irq_ctrl_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
//   Picks the lowest-index set bit of the request vector.
//   req_i   : candidate channels (pending and enabled)
//   valid_o : at least one candidate present
//   idx_o   : index of the lowest candidate, 0 when none
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
  parameter int NUM_CHANNELS = 4,
  parameter int IDW          = 2
) (
  input  logic [NUM_CHANNELS-1:0] req_i,
  output logic                    valid_o,
  output logic [IDW-1:0]          idx_o
);

  assign valid_o = |req_i;

  // Scanning from the top down lets the lowest set index overwrite the
  // others, so channel 0 always has the highest priority
  always_comb begin
    idx_o = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/frost32_irq_ctrl.sv
// ---------------------------------------------------------------------------
// frost32_irq_ctrl
//   Parametrised interrupt source for Frost32Cpu. Latches request lines into
//   pending bits, chooses the lowest enabled pending channel and drives the
//   CPU's single interrupt input as a pulse that stretches while MainMem
//   stalls, followed by a fixed cool-down gap.
//
//   Ports
//     clk  : system clock, all state on posedge
//     rst  : asynchronous active-high reset
//     bus  : frost32_irq_ctrl_if.slave
//              irq_src/irq_mask/wait_for_mem in, interrupt/irq_id/pending/busy out
//
//   Configuration
//     IRQ_CTRL_EDGE_DETECT_EN : when defined, each request line goes through a
//       two-flop synchroniser and only a rising edge sets its pending bit.
//       When undefined, a high request line sets its pending bit every cycle.
// ---------------------------------------------------------------------------
module frost32_irq_ctrl
  import frost32_irq_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  frost32_irq_ctrl_if.slave       bus
);

  localparam int IDW = idWidth(NUM_CHANNELS);
  localparam int CW  = countWidth(PULSE_CYCLES, GAP_CYCLES);

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS) begin : g_badChannelCount
    $error("frost32_irq_ctrl: NUM_CHANNELS out of range");
  end

  IrqCtrlState             state_q;
  logic                    interrupt_q;
  logic                    busy_q;
  logic [IDW-1:0]          irqId_q;
  logic [CW-1:0]           count_q;
  logic [NUM_CHANNELS-1:0] pending_q;
  logic [NUM_CHANNELS-1:0] pending_d;

  logic [NUM_CHANNELS-1:0] capture_w;
  logic [NUM_CHANNELS-1:0] clear_w;
  logic                    anyValid_w;
  logic [IDW-1:0]          selId_w;
  logic                    take_w;

`ifdef IRQ_CTRL_EDGE_DETECT_EN
  logic [NUM_CHANNELS-1:0] sync1_q;
  logic [NUM_CHANNELS-1:0] sync2_q;
  logic [NUM_CHANNELS-1:0] prev_q;

  // Two-flop synchroniser followed by a history flop; everything resets to 0
  // so a line already high when reset releases is seen as a fresh edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.irq_src;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign capture_w = sync2_q & ~prev_q;
`else
  assign capture_w = bus.irq_src;
`endif

  // Masked channels still collect pending bits; only the choice is masked
  irq_priority_encoder #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDW          (IDW)
  ) u_prio (
    .req_i   (pending_q & bus.irq_mask),
    .valid_o (anyValid_w),
    .idx_o   (selId_w)
  );

  assign take_w  = (state_q == IDLE) && anyValid_w;
  assign clear_w = take_w ? (NUM_CHANNELS'(1) << selId_w) : '0;

  // A capture in the same cycle as the clear wins, so a request arriving just
  // as its channel is taken is not lost and fires again later
  assign pending_d = (pending_q & ~clear_w) | capture_w;

  // Pending register update, kept apart from the state machine so the
  // set-wins rule lives in one place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Controller state machine with registered outputs. The counter holds the
  // remaining pulse cycles in ASSERT (frozen during memory stalls) and the
  // remaining cool-down cycles in GAP (never frozen)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
      irqId_q     <= '0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyValid_w) begin
            state_q     <= ASSERT;
            irqId_q     <= selId_w;
            interrupt_q <= 1'b1;
            busy_q      <= 1'b1;
            count_q     <= PULSE_LOAD;
          end
        end
        ASSERT: begin
          if (!bus.wait_for_mem) begin
            if (count_q == '0) begin
              interrupt_q <= 1'b0;
              if (GAP_CYCLES == 0) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= GAP;
                count_q <= GAP_LOAD;
              end
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end
        GAP: begin
          if (count_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          interrupt_q <= 1'b0;
          busy_q      <= 1'b0;
          count_q     <= '0;
        end
      endcase
    end
  end

  assign bus.interrupt = interrupt_q;
  assign bus.irq_id    = irqId_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_frost32_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frost32_irq_ctrl
//   Self-checking bench for frost32_irq_ctrl with N=4, P=2, G=4 in the default
//   level-sensitive build. Per-cycle vectors are queued as expectations when
//   driven and popped when the registered outputs settle after the edge.
// ---------------------------------------------------------------------------
module tb_frost32_irq_ctrl;
  import frost32_irq_ctrl_pkg::*;

  localparam int N = 4;
  localparam int P = 2;
  localparam int G = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frost32_irq_ctrl_if #(.NUM_CHANNELS(N)) bus ();

  frost32_irq_ctrl #(
    .NUM_CHANNELS (N),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 time-unit clock period
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] src;
    logic [3:0] mask;
    logic       wfm;
    logic       expInt;
    logic [1:0] expId;
    logic [3:0] expPend;
    logic       expBusy;
  } Vec;

  Vec vecs[$];
  Vec expQ[$];
  int total = 0;
  int bad   = 0;

  // Appends one per-cycle vector: inputs for the cycle, outputs after the edge
  task automatic addVec(input string nm, input logic [3:0] s, input logic [3:0] m,
                        input logic w, input logic ei, input logic [1:0] id,
                        input logic [3:0] p, input logic eb);
    Vec v;
    v.name = nm; v.src = s; v.mask = m; v.wfm = w;
    v.expInt = ei; v.expId = id; v.expPend = p; v.expBusy = eb;
    vecs.push_back(v);
  endtask

  // Appends a run of identical vectors
  task automatic addRep(input int n, input string nm, input logic [3:0] s, input logic [3:0] m,
                        input logic w, input logic ei, input logic [1:0] id,
                        input logic [3:0] p, input logic eb);
    for (int i = 0; i < n; i++) addVec(nm, s, m, w, ei, id, p, eb);
  endtask

  // Single comparison; every check in the bench goes through here
  task automatic checkVal(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Drives one vector at the falling edge and records what it should produce
  task automatic applyStimulus(input Vec v);
    @(negedge clk);
    bus.irq_src      = v.src;
    bus.irq_mask     = v.mask;
    bus.wait_for_mem = v.wfm;
    expQ.push_back(v);
  endtask

  // Waits for the edge, lets outputs settle, then pops and compares
  task automatic checkOutput(input int idx);
    Vec e;
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkVal($sformatf("scoreboard_empty_%0d", idx), 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkVal($sformatf("%s[%0d].interrupt", e.name, idx), 32'(bus.interrupt), 32'(e.expInt));
      checkVal($sformatf("%s[%0d].irq_id",    e.name, idx), 32'(bus.irq_id),    32'(e.expId));
      checkVal($sformatf("%s[%0d].pending",   e.name, idx), 32'(bus.pending),   32'(e.expPend));
      checkVal($sformatf("%s[%0d].busy",      e.name, idx), 32'(bus.busy),      32'(e.expBusy));
    end
  endtask

  initial begin
    int rises;
    int firstRise;
    int lastRise;
    int period;
    int extra;
    int cyc;
    logic prevInt;
    logic drained;

    bus.irq_src      = '0;
    bus.irq_mask     = 4'hF;
    bus.wait_for_mem = 1'b0;

    // ---------------- reset state, request ignored during reset ----------
    @(negedge clk);
    bus.irq_src = 4'b0100;
    @(posedge clk);
    #1;
    checkVal("reset.interrupt", 32'(bus.interrupt), 32'd0);
    checkVal("reset.irq_id",    32'(bus.irq_id),    32'd0);
    checkVal("reset.pending",   32'(bus.pending),   32'd0);
    checkVal("reset.busy",      32'(bus.busy),      32'd0);
    @(negedge clk);
    bus.irq_src = '0;
    rst = 1'b0;

    // ---------------- vector table ---------------------------------------
    // single request on channel 2: two-cycle pulse then four gap cycles
    addVec("t1_cap",  4'b0100, 4'hF, 0, 0, 2'd0, 4'b0100, 0);
    addRep(2, "t1_pulse", 4'b0000, 4'hF, 0, 1, 2'd2, 4'b0000, 1);
    addRep(4, "t1_gap",   4'b0000, 4'hF, 0, 0, 2'd2, 4'b0000, 1);
    addVec("t1_idle", 4'b0000, 4'hF, 0, 0, 2'd2, 4'b0000, 0);
    // channels 1 and 3 together: id 1 first, then id 3 after the gap
    addVec("t2_cap",  4'b1010, 4'hF, 0, 0, 2'd2, 4'b1010, 0);
    addRep(2, "t2_pulse1", 4'b0000, 4'hF, 0, 1, 2'd1, 4'b1000, 1);
    addRep(4, "t2_gap1",   4'b0000, 4'hF, 0, 0, 2'd1, 4'b1000, 1);
    addVec("t2_between", 4'b0000, 4'hF, 0, 0, 2'd1, 4'b1000, 0);
    addRep(2, "t2_pulse3", 4'b0000, 4'hF, 0, 1, 2'd3, 4'b0000, 1);
    addRep(4, "t2_gap3",   4'b0000, 4'hF, 0, 0, 2'd3, 4'b0000, 1);
    addVec("t2_idle", 4'b0000, 4'hF, 0, 0, 2'd3, 4'b0000, 0);
    // memory stall for three cycles stretches the pulse to five
    addVec("t3_cap",   4'b0001, 4'hF, 0, 0, 2'd3, 4'b0001, 0);
    addVec("t3_pulse", 4'b0000, 4'hF, 0, 1, 2'd0, 4'b0000, 1);
    addRep(3, "t3_stall", 4'b0000, 4'hF, 1, 1, 2'd0, 4'b0000, 1);
    addVec("t3_pulse_end", 4'b0000, 4'hF, 0, 1, 2'd0, 4'b0000, 1);
    addRep(4, "t3_gap", 4'b0000, 4'hF, 0, 0, 2'd0, 4'b0000, 1);
    addVec("t3_idle", 4'b0000, 4'hF, 0, 0, 2'd0, 4'b0000, 0);
    // masked request persists, fires on unmask; mask drop mid-pulse ignored;
    // a request during the gap only latches
    addVec("t4_cap",  4'b0001, 4'b1110, 0, 0, 2'd0, 4'b0001, 0);
    addRep(2, "t4_masked", 4'b0000, 4'b1110, 0, 0, 2'd0, 4'b0001, 0);
    addVec("t4_unmask", 4'b0000, 4'hF,    0, 1, 2'd0, 4'b0000, 1);
    addVec("t4_maskoff_mid", 4'b0000, 4'b0000, 0, 1, 2'd0, 4'b0000, 1);
    addVec("t4_gap_req", 4'b0100, 4'b0000, 0, 0, 2'd0, 4'b0100, 1);
    addRep(3, "t4_gap",  4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0100, 1);
    addVec("t4_idle_masked", 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0100, 0);
    addRep(2, "t4_pulse2", 4'b0000, 4'hF, 0, 1, 2'd2, 4'b0000, 1);
    addRep(4, "t4_gap2",   4'b0000, 4'hF, 0, 0, 2'd2, 4'b0000, 1);
    addVec("t4_idle", 4'b0000, 4'hF, 0, 0, 2'd2, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // ---------------- reset mid-ASSERT -----------------------------------
    @(negedge clk);
    bus.irq_src  = 4'b0101;
    bus.irq_mask = 4'hF;
    @(posedge clk);
    #1;
    checkVal("t5_cap.pending", 32'(bus.pending), 32'h5);
    @(negedge clk);
    bus.irq_src = '0;
    @(posedge clk);
    #1;
    checkVal("t5_assert.interrupt", 32'(bus.interrupt), 32'd1);
    checkVal("t5_assert.irq_id",    32'(bus.irq_id),    32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkVal("t5_rst.interrupt", 32'(bus.interrupt), 32'd0);
    checkVal("t5_rst.busy",      32'(bus.busy),      32'd0);
    checkVal("t5_rst.pending",   32'(bus.pending),   32'd0);
    checkVal("t5_rst.irq_id",    32'(bus.irq_id),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkVal($sformatf("t5_after[%0d].interrupt", i), 32'(bus.interrupt), 32'd0);
      checkVal($sformatf("t5_after[%0d].pending", i),   32'(bus.pending),   32'd0);
    end

    // ---------------- level request held high for 20 cycles --------------
    rises = 0; firstRise = -1; lastRise = -1; period = -1;
    prevInt = bus.interrupt;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.irq_src = 4'b0001;
      @(posedge clk);
      #1;
      if (bus.interrupt && !prevInt) begin
        if (rises == 1) period = c - lastRise;
        if (rises == 0) firstRise = c;
        lastRise = c;
        rises++;
      end
      prevInt = bus.interrupt;
    end
    checkVal("t6_held.pulses",     32'(rises),     32'd3);
    checkVal("t6_held.first_rise", 32'(firstRise), 32'd1);
    checkVal("t6_held.period",     32'(period),    32'(P + G + 1));
    checkVal("t6_held.pending",    32'(bus.pending), 32'h1);

    // After release the last latched request fires once more, then all idles
    extra = 0; drained = 1'b0; cyc = 0;
    @(negedge clk);
    bus.irq_src = '0;
    while (!drained && cyc < 50) begin
      @(posedge clk);
      #1;
      if (bus.interrupt && !prevInt) extra++;
      prevInt = bus.interrupt;
      drained = !bus.busy && !bus.interrupt && (bus.pending == '0) && (extra > 0);
      cyc++;
    end
    checkVal("t6_drain.timeout",      32'(drained), 32'd1);
    checkVal("t6_drain.extra_pulses", 32'(extra),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
